regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised register file for the pipeline decode stage: 2 async read ports, 1 write
//  port, optional write-to-read bypass, hardwired zero register. Adds a per-register
//  pending scoreboard for the hazard unit, plus a post-reset clear sequencer that zeroes
//  the array one entry per cycle. Replaces the negedge-write fixed 32x32 file with a
//  posedge-write file plus bypass.
// PARAMETERS
//  DATA_W    32  data width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG  1   1: entry 0 reads 0, ignores writes, never pending
//  BYPASS    1   1: same-cycle write data forwarded to matching read port
// PORTS
//  clk         in   1       clock, all state updates on posedge
//  rst         in   1       synchronous reset, active-low
//  read1       in   ADDR_W  read port 1 address
//  read2       in   ADDR_W  read port 2 address
//  data1       out  DATA_W  read port 1 data (combinational)
//  data2       out  DATA_W  read port 2 data (combinational)
//  busy1       out  1       entry read1 has an outstanding producer
//  busy2       out  1       entry read2 has an outstanding producer
//  regWrite    in   1       write enable (writeback)
//  writeReg    in   ADDR_W  write address
//  writeData   in   DATA_W  write data
//  claim       in   1       issue: mark claimReg pending
//  claimReg    in   ADDR_W  destination being issued
//  flush       in   1       clear all pending bits (pipeline flush)
//  init_busy   out  1       clear sequence active; pipeline must stall
// BEHAVIOUR
//  FSM: CLEAR, RUN. rst=0 at a posedge -> CLEAR, clr_idx=0, all pend=0 (overrides all inputs).
//  CLEAR: each posedge writes 0 to RegFile[clr_idx], clr_idx+1; after writing DEPTH-1 -> RUN.
//   Exactly DEPTH cycles after rst returns high. regWrite/claim/flush ignored in CLEAR.
//   data1/data2=0, busy1/busy2=0, init_busy=1 in CLEAR and while rst=0.
//  RUN: init_busy=0. regWrite=1 -> RegFile[writeReg]<=writeData at posedge.
//  Read: dataN = RegFile[readN]; if ZERO_REG and readN==0 -> 0.
//   BYPASS=1 and regWrite and writeReg==readN (and not zero reg) -> dataN=writeData, busyN=0.
//  Scoreboard pend[DEPTH-1:0], updated at posedge in RUN, priority high->low:
//   flush -> all pend=0 (claim same cycle ignored, writes still performed);
//   claim -> pend[claimReg]=1; regWrite -> pend[writeReg]=0 unless writeReg==claimReg
//   with claim=1 (claim wins: newer producer). claimReg/writeReg 0 ignored when ZERO_REG.
//  busyN = pend[readN], except 0 when bypass hit (above) or ZERO_REG and readN==0.
//  BYPASS=0: busyN = pend[readN]; written data visible cycle after write edge.
//  Both read ports may address same entry; identical results. No X on outputs after reset.
//  rst low mid-CLEAR or mid-RUN: restart CLEAR from idx 0; all contents lost.
// TESTING
//  1 rst low 2 cycles then high -> init_busy=1 for exactly 32 cycles; all 32 entries read 0.
//  2 RUN: write r5=7; same cycle read1=5 -> data1=7 (BYPASS=1); next cycle data1=7 from array.
//  3 write r0=0xFFFF_FFFF, read r0 -> 0; claim r0 -> busy stays 0.
//  4 claim r3; next cycle busy1(read1=3)=1; write r3=9 -> same cycle busy1=0, data1=9; then pend=0.
//  5 claim r4 and write r4 same cycle -> r4 written, pend[4]=1 next cycle; flush -> busy 0.
//  6 rst low in RUN after writing r1=2 -> re-clear, r1 reads 0, pend all 0, init_busy 32 cycles.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with optional write-to-read bypass,
// zero register, pending scoreboard and post-reset clear sequencer.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   read1/read2         read addresses
//   data1/data2         combinational read data
//   busy1/busy2         read entry has an outstanding producer
//   regWrite/writeReg/writeData  writeback port
//   claim/claimReg      issue marks destination pending
//   flush               clear every pending bit
//   init_busy           clear sequence active; pipeline stalls
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read1,
    input  logic [ADDR_W-1:0] read2,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              claim,
    input  logic [ADDR_W-1:0] claimReg,
    input  logic              flush,
    output logic              init_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_nxt;
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic run;
    logic wr_ok;
    logic clm_ok;
    logic z1;
    logic z2;
    logic hit1;
    logic hit2;

    // Holding rst low also forces the idle/stall view immediately.
    assign run    = rst && (state == RUN);
    assign wr_ok  = run && regWrite && !(ZR && (writeReg == '0));
    assign clm_ok = run && claim && !(ZR && (claimReg == '0));

    assign z1   = ZR && (read1 == '0);
    assign z2   = ZR && (read2 == '0);
    assign hit1 = BP && wr_ok && (writeReg == read1);
    assign hit2 = BP && wr_ok && (writeReg == read2);

    assign data1 = (!run || z1) ? '0 :
                   hit1         ? writeData : mem[read1];
    assign data2 = (!run || z2) ? '0 :
                   hit2         ? writeData : mem[read2];

    // A forwarded value is already the producer's result.
    assign busy1 = run && !z1 && !hit1 && pend[read1];
    assign busy2 = run && !z2 && !hit2 && pend[read2];

    assign init_busy = !run;

    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_idx;
        pend_nxt  = pend;
        unique case (state)
            CLEAR: begin
                clr_nxt = clr_idx + ADDR_W'(1);
                if (clr_idx == '1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    pend_nxt = '0;
                end else begin
                    // Claim applied last: a newer producer wins.
                    if (wr_ok) begin
                        pend_nxt[writeReg] = 1'b0;
                    end
                    if (clm_ok) begin
                        pend_nxt[claimReg] = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            pend    <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_nxt;
            pend    <= pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (wr_ok) begin
                mem[writeReg] <= writeData;
            end
        end
    end

endmodule
